// File: rtl/n64_tx_sequencer.sv
// rtl/n64_tx_sequencer.sv - N64 console->controller command sequencer: bit cells, stop bit, response window.
// Optional response timeout enabled by defining N64_TX_TIMEOUT_EN.
module n64_tx_sequencer #(
    parameter int CLK_PER_US = 12,
    parameter int CMD_BITS   = 8,
    parameter int TIMEOUT_US = 100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [CMD_BITS-1:0] cmd,
    input  logic                rx_done,
    output logic                line_oe,
    output logic                busy,
    output logic                rx_window,
    output logic [4:0]          bit_index,
    output logic                done,
    output logic                timeout
);

    localparam int Q  = CLK_PER_US;
    localparam int CW = $clog2(4 * CLK_PER_US);
    localparam logic [CW-1:0] Q_V       = CW'(Q);
    localparam logic [CW-1:0] Q3_V      = CW'(3 * Q);
    localparam logic [CW-1:0] CELL_LAST = CW'(4 * Q - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(3 * Q - 1);
    localparam logic [4:0]    BI_TOP    = 5'(CMD_BITS - 1);

    if (CMD_BITS < 1 || CMD_BITS > 16 || TIMEOUT_US < 1 || CLK_PER_US < 1) begin : g_bad_params
        $error("n64_tx_sequencer: parameter out of range");
    end

    typedef enum logic [1:0] {S_IDLE, S_BIT, S_STOP, S_RXWAIT} state_t;

    state_t              state;
    logic [CMD_BITS-1:0] shreg;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_nxt;
    logic                cur_bit;

    assign cnt_nxt = cnt + 1'b1;
    assign cur_bit = shreg[CMD_BITS-1];

`ifdef N64_TX_TIMEOUT_EN
    localparam int TO_CYC = TIMEOUT_US * CLK_PER_US;
    localparam int TW     = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

    logic [TW-1:0] tcnt;
    logic          timeout_r;

    assign timeout = timeout_r;
`else
    assign timeout = 1'b0;
`endif

    // line_oe is registered, so each cycle drives the level belonging to the next counter value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            shreg     <= '0;
            cnt       <= '0;
            line_oe   <= 1'b0;
            busy      <= 1'b0;
            rx_window <= 1'b0;
            bit_index <= '0;
            done      <= 1'b0;
`ifdef N64_TX_TIMEOUT_EN
            tcnt      <= '0;
            timeout_r <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef N64_TX_TIMEOUT_EN
            timeout_r <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    line_oe <= 1'b0;
                    if (start) begin
                        shreg     <= cmd;
                        bit_index <= BI_TOP;
                        cnt       <= '0;
                        state     <= S_BIT;
                        busy      <= 1'b1;
                        line_oe   <= 1'b1;
                    end
                end
                S_BIT: begin
                    if (cnt == CELL_LAST) begin
                        cnt     <= '0;
                        line_oe <= 1'b1;
                        shreg   <= shreg << 1;
                        if (bit_index == 5'd0) begin
                            state <= S_STOP;
                        end else begin
                            bit_index <= bit_index - 5'd1;
                        end
                    end else begin
                        cnt     <= cnt_nxt;
                        line_oe <= cur_bit ? (cnt_nxt < Q_V) : (cnt_nxt < Q3_V);
                    end
                end
                S_STOP: begin
                    if (cnt == STOP_LAST) begin
                        cnt       <= '0;
                        line_oe   <= 1'b0;
                        rx_window <= 1'b1;
                        state     <= S_RXWAIT;
`ifdef N64_TX_TIMEOUT_EN
                        tcnt      <= '0;
`endif
                    end else begin
                        cnt     <= cnt_nxt;
                        line_oe <= (cnt_nxt < Q_V);
                    end
                end
                S_RXWAIT: begin
                    line_oe <= 1'b0;
                    if (rx_done) begin
                        state     <= S_IDLE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        rx_window <= 1'b0;
`ifdef N64_TX_TIMEOUT_EN
                    end else if (tcnt == TO_LAST) begin
                        state     <= S_IDLE;
                        done      <= 1'b1;
                        timeout_r <= 1'b1;
                        busy      <= 1'b0;
                        rx_window <= 1'b0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_n64_tx_sequencer.sv
// tb/tb_n64_tx_sequencer.sv - directed self-checking bench for n64_tx_sequencer (Q=4, 8-bit commands).
module tb_n64_tx_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] cmd = 8'h00;
    logic       rx_done = 1'b0;
    logic       line_oe, busy, rx_window, done, timeout;
    logic [4:0] bit_index;

    int checks = 0;
    int errors = 0;

    n64_tx_sequencer #(
        .CLK_PER_US(4),
        .CMD_BITS  (8),
        .TIMEOUT_US(10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .cmd      (cmd),
        .rx_done  (rx_done),
        .line_oe  (line_oe),
        .busy     (busy),
        .rx_window(rx_window),
        .bit_index(bit_index),
        .done     (done),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Leaves the bench at the first sampled cycle after the accepting edge.
    task automatic begin_frame(input logic [7:0] c);
        cmd   = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Checks 140 drive cycles; returns at the first RXWAIT cycle (rx_window just risen).
    task automatic check_frame(input logic [7:0] c, input bit noise);
        int hi;
        for (int i = 7; i >= 0; i--) begin
            hi = c[i] ? 4 : 12;
            for (int k = 0; k < 16; k++) begin
                chk($sformatf("oe b%0d c%0d", i, k), line_oe, (k < hi) ? 1 : 0);
                chk($sformatf("bit_index b%0d c%0d", i, k), bit_index, i);
                chk("busy in bit", busy, 1);
                chk("rx_window in bit", rx_window, 0);
                if (noise && i > 0) begin
                    start   = 1'b1;
                    cmd     = 8'hAA;
                    rx_done = 1'b1;
                end
                tick();
            end
        end
        if (noise) begin
            start   = 1'b0;
            rx_done = 1'b0;
        end
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("oe stop c%0d", k), line_oe, (k < 4) ? 1 : 0);
            chk("rx_window in stop", rx_window, 0);
            tick();
        end
        chk("rx_window rise", rx_window, 1);
        chk("oe rxwait", line_oe, 0);
        chk("busy rxwait", busy, 1);
    endtask

    task automatic finish_rx(input string tag);
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        chk({tag, " done"}, done, 1);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " rx_window"}, rx_window, 0);
        chk({tag, " timeout"}, timeout, 0);
        tick();
        chk({tag, " done pulse"}, done, 0);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst line_oe", line_oe, 0);
        chk("rst busy", busy, 0);
        chk("rst rx_window", rx_window, 0);
        chk("rst bit_index", bit_index, 0);
        chk("rst done", done, 0);
        chk("rst timeout", timeout, 0);
        reset = 1'b1;
        tick();

        // 1: all-zero command, rx_window in the 141st cycle after accept
        begin_frame(8'h00);
        check_frame(8'h00, 1'b0);
        finish_rx("t1");

        // 2 + 6a: 0x80 with stray start/cmd/rx_done during bit cells
        begin_frame(8'h80);
        check_frame(8'h80, 1'b1);
        finish_rx("t2");

        // 3: 0xFF, rx_done 20 cycles into RXWAIT
        begin_frame(8'hFF);
        check_frame(8'hFF, 1'b0);
        for (int k = 1; k < 20; k++) begin
            tick();
            chk("t3 wait done", done, 0);
            chk("t3 wait rx_window", rx_window, 1);
        end
        finish_rx("t3");

        // 4: response window expiry
        begin_frame(8'h5A);
        check_frame(8'h5A, 1'b0);
`ifdef N64_TX_TIMEOUT_EN
        for (int k = 1; k < 40; k++) begin
            tick();
            chk("t4 pre done", done, 0);
            chk("t4 pre timeout", timeout, 0);
        end
        tick();
        chk("t4 done", done, 1);
        chk("t4 timeout", timeout, 1);
        chk("t4 busy", busy, 0);
        chk("t4 rx_window", rx_window, 0);
        tick();
        chk("t4 timeout pulse", timeout, 0);
        // rx_done on the expiry cycle wins
        begin_frame(8'h01);
        check_frame(8'h01, 1'b0);
        for (int k = 1; k < 40; k++) tick();
        finish_rx("t4 race");
`else
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (k % 250 == 0) chk("t4 no done", done, 0);
        end
        chk("t4 busy at 1000", busy, 1);
        chk("t4 rx_window at 1000", rx_window, 1);
        chk("t4 timeout tied", timeout, 0);
        finish_rx("t4");
`endif

        // 5: reset during bit 5 while line_oe is high
        begin_frame(8'h00);
        for (int k = 1; k < 33; k++) tick();
        chk("t5 pre bit_index", bit_index, 5);
        chk("t5 pre oe", line_oe, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("t5 oe", line_oe, 0);
        chk("t5 busy", busy, 0);
        chk("t5 bit_index", bit_index, 0);
        tick();
        chk("t5 idle oe", line_oe, 0);
        chk("t5 idle busy", busy, 0);
        begin_frame(8'h3C);
        check_frame(8'h3C, 1'b0);
        finish_rx("t5");

        // 6b: start held through done -> next frame the cycle after done
        cmd   = 8'hC3;
        start = 1'b1;
        tick();
        check_frame(8'hC3, 1'b0);
        cmd     = 8'h81;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        chk("t6 done", done, 1);
        chk("t6 done busy", busy, 0);
        tick();
        start = 1'b0;
        chk("t6 back2back busy", busy, 1);
        chk("t6 back2back oe", line_oe, 1);
        chk("t6 back2back done", done, 0);
        check_frame(8'h81, 1'b0);
        finish_rx("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
